// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory stream loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_WIDTH         = 16;
  localparam int         BYTE_WIDTH        = 8;
  localparam int         CSUM_WIDTH        = 8;

endpackage

// File: rtl/imem_stream_loader.sv
// Receives a framed byte stream and writes it into instruction RAM, holding the
// core in reset until a frame passes its length and checksum checks.
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 12,
  parameter int         MAX_WORDS  = 2 ** (ADDR_WIDTH - 2),
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [BYTE_WIDTH-1:0] imem_wdata,
  output logic                  core_reset,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [LEN_WIDTH-1:0]  words_loaded
);

  localparam logic [LEN_WIDTH:0] MAX_LEN = (LEN_WIDTH + 1)'(MAX_WORDS);

  loader_state_e         state, state_next;
  logic [7:0]            len_hi;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  len_word;
  logic [ADDR_WIDTH-1:0] index;
  logic [CSUM_WIDTH-1:0] checksum;
  logic                  accept;
  logic                  is_sync;
  logic                  len_bad;
  logic                  last_byte;

  assign rx_ready  = 1'b1;
  assign accept    = rx_valid;
  assign is_sync   = (rx_data == SYNC_BYTE);
  assign len_word  = {len_hi, rx_data};
  assign len_bad   = (len_word == '0) || ({1'b0, len_word} > MAX_LEN);
  // The final payload byte closes the word that brings the count up to LEN.
  assign last_byte = (index[1:0] == 2'b11) && ((words_loaded + 16'd1) == len);

  // Status outputs are decoded from the registered state, so they move one
  // cycle after the byte that decides them.
  assign core_reset = (state != DONE);
  assign load_done  = (state == DONE);
  assign load_error = (state == ERROR);
  assign load_busy  = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == PAYLOAD) || (state == CHECK);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        IDLE, DONE, ERROR: if (is_sync) state_next = LEN_HI;
        LEN_HI:            state_next = LEN_LO;
        LEN_LO:            state_next = len_bad ? ERROR : PAYLOAD;
        PAYLOAD:           if (last_byte) state_next = CHECK;
        CHECK:             state_next = (rx_data == checksum) ? DONE : ERROR;
        default:           state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      len_hi       <= '0;
      len          <= '0;
      index        <= '0;
      checksum     <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (is_sync) begin
              words_loaded <= '0;
              checksum     <= '0;
              index        <= '0;
            end
          end
          LEN_HI: len_hi <= rx_data;
          LEN_LO: begin
            len   <= len_word;
            index <= '0;
          end
          PAYLOAD: begin
            imem_we    <= 1'b1;
            imem_addr  <= index;
            imem_wdata <= rx_data;
            checksum   <= checksum + rx_data;
            index      <= index + ADDR_WIDTH'(1);
            if (index[1:0] == 2'b11) words_loaded <= words_loaded + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: frames are built from byte lists and
// the expected RAM writes and final status come from the frame rules directly.
module tb_imem_stream_loader;

  localparam int ADDR_WIDTH = 12;
  localparam int MAX_WORDS  = 1024;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data;
  } wr_t;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  rx_valid = 1'b0;
  logic [7:0]            rx_data = 8'h00;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [7:0]            imem_wdata;
  logic                  core_reset;
  logic                  load_busy;
  logic                  load_done;
  logic                  load_error;
  logic [15:0]           words_loaded;

  int      tests = 0;
  int      fails = 0;
  int      gap_mode = 0;
  wr_t     exp_q[$];
  wr_t     mon_exp;
  byte_q_t golden;

  imem_stream_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .load_busy(load_busy),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Every write the DUT makes must match the oldest outstanding expected write.
  always @(negedge clock) begin
    if (reset && imem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("write_addr", 32'(imem_addr), 32'(mon_exp.addr));
        check_output("write_data", 32'(imem_wdata), 32'(mon_exp.data));
      end
    end
  end

  function automatic logic [7:0] payload_sum(input byte_q_t p);
    int s = 0;
    foreach (p[i]) s += int'(p[i]);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    int gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
    repeat (gaps) begin
      @(posedge clock);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && waited < 8) begin
      @(posedge clock);
      #1;
      waited++;
    end
    if (!rx_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL rx_ready_timeout: got 0, expected 1");
    end
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_garbage(input int n);
    logic [7:0] g;
    for (int i = 0; i < n; i++) begin
      g = 8'($urandom_range(0, 255));
      if (g == 8'hA5) g = 8'h5A;
      send_byte(g);
    end
  endtask

  // Sends one complete frame and checks the status the frame rules predict.
  task automatic apply_stimulus(input logic [15:0] len, input byte_q_t payload,
                                input logic [7:0] csum);
    bit len_ok = (len != 16'd0) && (int'(len) <= MAX_WORDS);
    bit good;
    send_byte(8'hA5);
    check_output("sync_core_reset", 32'(core_reset), 32'd1);
    check_output("sync_busy", 32'(load_busy), 32'd1);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    if (!len_ok) begin
      check_output("len_error", 32'(load_error), 32'd1);
      check_output("len_core_reset", 32'(core_reset), 32'd1);
      check_output("len_done", 32'(load_done), 32'd0);
      check_output("len_words", 32'(words_loaded), 32'd0);
    end else begin
      for (int k = 0; k < payload.size(); k++) begin
        exp_q.push_back('{addr: ADDR_WIDTH'(k), data: payload[k]});
        send_byte(payload[k]);
      end
      check_output("pre_csum_core_reset", 32'(core_reset), 32'd1);
      good = (csum == payload_sum(payload));
      send_byte(csum);
      check_output("core_reset", 32'(core_reset), 32'(!good));
      check_output("load_done", 32'(load_done), 32'(good));
      check_output("load_error", 32'(load_error), 32'(!good));
      check_output("load_busy", 32'(load_busy), 32'd0);
      check_output("words_loaded", 32'(words_loaded), 32'(len));
    end
    @(negedge clock);
    #1;
    check_output("writes_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte_q_t p;
    logic [15:0] len;
    logic [7:0]  cs;
    golden = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h50, 8'h00, 8'h93,
               8'h00, 8'h50, 8'h01, 8'h13, 8'hFE, 8'h20, 8'h9C, 8'hE3};

    #1;
    check_output("rst_core_reset", 32'(core_reset), 32'd1);
    check_output("rst_rx_ready", 32'(rx_ready), 32'd1);
    check_output("rst_we", 32'(imem_we), 32'd0);
    check_output("rst_busy", 32'(load_busy), 32'd0);
    check_output("rst_done", 32'(load_done), 32'd0);
    check_output("rst_error", 32'(load_error), 32'd0);
    check_output("rst_words", 32'(words_loaded), 32'd0);
    check_output("rst_addr", 32'(imem_addr), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    apply_stimulus(16'd4, golden, 8'hE4);

    send_garbage(0);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    check_output("garbage_in_done", 32'(core_reset), 32'd0);
    apply_stimulus(16'd4, golden, 8'hE4);

    apply_stimulus(16'd4, golden, 8'hE5);
    apply_stimulus(16'd0, golden, 8'h00);
    apply_stimulus(16'h0401, golden, 8'h00);

    gap_mode = 1;
    apply_stimulus(16'd4, golden, 8'hE4);
    gap_mode = 0;

    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h04);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back('{addr: ADDR_WIDTH'(k), data: golden[k]});
      send_byte(golden[k]);
    end
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_output("midrst_we", 32'(imem_we), 32'd0);
    check_output("midrst_core_reset", 32'(core_reset), 32'd1);
    check_output("midrst_busy", 32'(load_busy), 32'd0);
    check_output("midrst_drained", 32'(exp_q.size()), 32'd0);
    #1;
    reset = 1'b1;
    apply_stimulus(16'd4, golden, 8'hE4);

    p = {};
    for (int i = 0; i < MAX_WORDS * 4; i++) p.push_back(8'($urandom));
    apply_stimulus(16'(MAX_WORDS), p, payload_sum(p));

    for (int f = 0; f < 25; f++) begin
      gap_mode = int'($urandom_range(0, 2));
      send_garbage(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(MAX_WORDS + 1, 65535));
        p = {};
        apply_stimulus(len, p, 8'h00);
      end else begin
        len = 16'($urandom_range(1, 16));
        p = {};
        for (int i = 0; i < int'(len) * 4; i++) p.push_back(8'($urandom));
        cs = payload_sum(p);
        if ($urandom_range(0, 3) == 0) cs = cs ^ (8'h01 << $urandom_range(0, 7));
        apply_stimulus(len, p, cs);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Hardware counterpart of the bench-side instruction preload: accepts a framed byte stream from a host link (UART receiver or debug bridge) and writes it into the fetch-stage instruction RAM through its byte write port.
- Holds the core in reset for the whole load and releases it only after a length- and checksum-verified frame.
- Sits between the host receive FIFO and the InstructionFetch instruction memory. Its core_reset output drives the Core reset input.

Parameters:
- ADDR_WIDTH, 12, byte address width of instruction RAM (4 KiB).
- MAX_WORDS, 2**(ADDR_WIDTH-2), largest accepted word count.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  host byte valid.
- rx_data  in  8  host byte.
- rx_ready  out  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready.
- imem_we  out  1  instruction RAM byte write enable.
- imem_addr  out  ADDR_WIDTH  instruction RAM byte address.
- imem_wdata  out  8  instruction RAM write byte.
- core_reset  out  1  active-high reset to Core.
- load_busy  out  1  frame in progress.
- load_done  out  1  last frame verified; core running.
- load_error  out  1  last frame rejected.
- words_loaded  out  16  words written by the current or last frame.

Behaviour:
- Reset (asynchronous assert on reset=0):
  - State IDLE; core_reset=1; rx_ready=1.
  - imem_we, load_busy, load_done, load_error = 0; words_loaded=0; imem_addr=0; checksum=0.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then LEN*4 payload bytes, then CSUM.
  - LEN is a 16-bit word count, big-endian.
  - CSUM is the sum of the payload bytes mod 256.
- Byte order: payload byte k is written to address k, so each word is MSB first. Word w bits [31:24] go to address 4w, bits [7:0] to address 4w+3.
- States:
  - IDLE: non-sync bytes are consumed and discarded. SYNC_BYTE -> LEN_HI, setting load_busy=1, core_reset=1, load_done=0, load_error=0, words_loaded=0, checksum=0.
  - LEN_HI -> LEN_LO on each accepted byte.
  - LEN_LO: if LEN==0 or LEN>MAX_WORDS -> ERROR; otherwise -> PAYLOAD with byte counter=0.
  - PAYLOAD: each accepted byte is added to the checksum and issues one write. After byte LEN*4-1 -> CHECK. words_loaded increments when byte index[1:0]==3.
  - CHECK: if the accepted byte equals the checksum -> DONE, else -> ERROR.
  - DONE: core_reset=0, load_done=1, load_busy=0. rx_ready=1. A SYNC_BYTE starts a new frame (core_reset reasserts the next cycle); other bytes are discarded.
  - ERROR: core_reset=1, load_error=1, load_busy=0. A SYNC_BYTE restarts; other bytes are discarded.
- Write timing: a payload byte accepted in cycle n gives imem_we=1 in cycle n+1, with imem_addr=index and imem_wdata=byte, all registered. imem_we is a one-cycle pulse per byte and is never asserted outside PAYLOAD acceptance.
- Flow control:
  - rx_ready is 1 in every state; the loader never back-pressures.
  - Gaps in rx_valid stall the FSM with no side effects. The write port is fire-and-forget.
- Bad frames: RAM contents are overwritten before the checksum is verified. core_reset staying 1 is the protection against running them.
- Output timing: core_reset, load_done and load_error change one cycle after the deciding byte is accepted.
- Address arithmetic: index is ADDR_WIDTH bits and cannot wrap because of the MAX_WORDS check.
- Reset mid-frame: returns to IDLE immediately; any partial RAM contents remain.

Decomposition:
- Package imem_loader_pkg:
  - loader_state_e enum: IDLE, LEN_HI, LEN_LO, PAYLOAD, CHECK, DONE, ERROR.
  - SYNC_BYTE default and the frame field widths.
- No sub-module is needed. The checksum/byte-counter datapath stays inline.

Test Plan:
- Golden load: frame A5 00 04 00 00 00 00 00 50 00 93 00 50 01 13 FE 20 9C E3 E4.
  - Required: 16 single-cycle writes to addr 0..15 with those bytes in order.
  - Required: core_reset falls one cycle after E4; load_done=1; words_loaded=4.
- Bad checksum: same frame with CSUM=E5 -> same 16 writes; load_error=1; core_reset stays 1; load_done=0.
- Garbage, then sync: 00 FF 13 followed by the golden frame -> first three bytes produce no writes; result identical to the golden load.
- Length limits: A5 00 00 -> ERROR after LEN_LO, with no writes. A5 04 01 at ADDR_WIDTH=12 (1025 > 1024) -> ERROR.
- Stalls, then reset: golden frame with rx_valid toggling every other cycle -> identical writes. Separately, reset=0 asserted after payload byte 7 -> IDLE, imem_we=0, core_reset=1; a following golden frame loads correctly.
- Reload: after DONE, send the golden frame again -> core_reset rises the cycle after A5 and falls again after a valid CSUM.
